// File: rtl/dac_segmented_encoder_dwa_if.sv
// Purpose : bundles the sample input and the cell-drive outputs of the segmented DAC encoder.
// Latency : none; this is only wiring.
// Backpress: none; the encoder accepts one sample per clock and never stalls.
//
// Ports (master = baseband side, slave = encoder):
//   en_i, mode_i, valid_i, data_i          master -> slave
//   therm_o, binary_o, valid_o, en_o,
//   pointer_o                              slave -> master
interface dac_segmented_encoder_dwa_if #(
    parameter int INPUT_WIDTH = 10,
    parameter int THERM_BITS  = 4
);
    localparam int UNITS = 2**THERM_BITS - 1;

    logic                              en_i;
    logic [1:0]                        mode_i;
    logic                              valid_i;
    logic [INPUT_WIDTH-1:0]            data_i;
    logic [UNITS-1:0]                  therm_o;
    logic [INPUT_WIDTH-THERM_BITS-1:0] binary_o;
    logic                              valid_o;
    logic                              en_o;
    logic [THERM_BITS-1:0]             pointer_o;

    modport master (
        output en_i, mode_i, valid_i, data_i,
        input  therm_o, binary_o, valid_o, en_o, pointer_o
    );

    modport slave (
        input  en_i, mode_i, valid_i, data_i,
        output therm_o, binary_o, valid_o, en_o, pointer_o
    );
endinterface

// File: rtl/dac_segmented_encoder_dwa.sv
// Purpose : segmented DAC encoder; MSBs -> rotated thermometer unit cells, LSBs -> binary cells.
// Latency : fixed 2 cycles from data_i/valid_i/en_i to all outputs.
// Backpress: none; one sample per clock, valid/enable travel alongside the data.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     slave side of dac_segmented_encoder_dwa_if (mode 0/3 static, 1 random rotation, 2 DWA)
//
// THERM_BITS must be in 2..min(INPUT_WIDTH-1, 15); the random offset is taken from the
// low THERM_BITS of the 15-bit LFSR.
module dac_segmented_encoder_dwa #(
    parameter int          INPUT_WIDTH = 10,
    parameter int          THERM_BITS  = 4,
    parameter logic [14:0] LFSR_SEED   = 15'h0001
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    dac_segmented_encoder_dwa_if.slave   bus
);
    localparam int UNITS = 2**THERM_BITS - 1;
    localparam int BIN_W = INPUT_WIDTH - THERM_BITS;

    typedef enum logic [1:0] {
        MODE_STATIC     = 2'd0,
        MODE_RANDOM     = 2'd1,
        MODE_DWA        = 2'd2,
        MODE_STATIC_ALT = 2'd3
    } mode_e;

    // Stage 1
    logic [THERM_BITS-1:0] r_n1;
    logic [BIN_W-1:0]      r_bin1;
    logic                  r_vld1;
    logic                  r_en1;
    mode_e                 r_mode1;

    // Stage 2 / outputs
    logic [UNITS-1:0]      r_therm;
    logic [BIN_W-1:0]      r_bin2;
    logic                  r_vld2;
    logic                  r_en2;
    logic [THERM_BITS-1:0] r_ptr;

    logic [14:0]           r_lfsr;

    logic [UNITS-1:0]      w_therm_raw;
    logic [THERM_BITS-1:0] w_off;
    logic [THERM_BITS-1:0] w_shamt;
    logic [2*UNITS-1:0]    w_dbl;
    logic [2*UNITS-1:0]    w_shifted;
    logic [UNITS-1:0]      w_therm_rot;
    logic [THERM_BITS:0]   w_ptr_sum;
    logic [THERM_BITS-1:0] w_ptr_next;
    logic                  w_live;

    assign w_live = r_vld1 & r_en1;

    // Thermometer code: the n lowest cells on.
    always_comb begin
        w_therm_raw = '0;
        for (int i = 0; i < UNITS; i++) begin
            w_therm_raw[i] = (THERM_BITS'(i) < r_n1);
        end
    end

    // Rotation offset; an LFSR value of UNITS would be a full turn, so it folds to 0.
    always_comb begin
        w_off = '0;
        case (r_mode1)
            MODE_RANDOM: w_off = (r_lfsr[THERM_BITS-1:0] == THERM_BITS'(UNITS)) ?
                                 '0 : r_lfsr[THERM_BITS-1:0];
            MODE_DWA:    w_off = r_ptr;
            default:     w_off = '0;
        endcase
    end

    // Rotate-left modulo UNITS: shift a doubled copy right by (UNITS - off) and keep
    // the low UNITS bits, so bit UNITS-1 wraps to bit 0 rather than to a 2**k boundary.
    assign w_dbl       = {w_therm_raw, w_therm_raw};
    assign w_shamt     = THERM_BITS'(UNITS) - w_off;
    assign w_shifted   = w_dbl >> w_shamt;
    assign w_therm_rot = w_shifted[UNITS-1:0];

    // p + n never exceeds 2*UNITS-1, so a single conditional subtract is a full modulo.
    // n = UNITS therefore leaves the pointer where it was.
    assign w_ptr_sum  = {1'b0, r_ptr} + {1'b0, r_n1};
    assign w_ptr_next = (w_ptr_sum >= (THERM_BITS+1)'(UNITS)) ?
                        THERM_BITS'(w_ptr_sum - (THERM_BITS+1)'(UNITS)) :
                        w_ptr_sum[THERM_BITS-1:0];

    // x^15 + x^14 + 1 Fibonacci LFSR; free-runs while enabled, from a non-zero seed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= LFSR_SEED;
        end else if (bus.en_i) begin
            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_n1    <= '0;
            r_bin1  <= '0;
            r_vld1  <= 1'b0;
            r_en1   <= 1'b0;
            r_mode1 <= MODE_STATIC;
        end else begin
            r_n1    <= bus.data_i[INPUT_WIDTH-1 -: THERM_BITS];
            r_bin1  <= bus.data_i[BIN_W-1:0];
            r_vld1  <= bus.valid_i;
            r_en1   <= bus.en_i;
            r_mode1 <= mode_e'(bus.mode_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_therm <= '0;
            r_bin2  <= '0;
            r_vld2  <= 1'b0;
            r_en2   <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_therm <= w_live ? w_therm_rot : '0;
            r_bin2  <= w_live ? r_bin1 : '0;
            r_vld2  <= r_vld1;
            r_en2   <= r_en1;
            // Leaving DWA restarts the pointer; idle or disabled DWA samples keep it.
            if (r_mode1 != MODE_DWA) begin
                r_ptr <= '0;
            end else if (w_live) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign bus.therm_o   = r_therm;
    assign bus.binary_o  = r_bin2;
    assign bus.valid_o   = r_vld2;
    assign bus.en_o      = r_en2;
    assign bus.pointer_o = r_ptr;

endmodule

// File: tb/tb_dac_segmented_encoder_dwa.sv
module tb_dac_segmented_encoder_dwa;
    localparam int          IW    = 10;
    localparam int          TB    = 4;
    localparam int          UNITS = 15;
    localparam logic [14:0] SEED  = 15'h0001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dac_segmented_encoder_dwa_if #(.INPUT_WIDTH(IW), .THERM_BITS(TB)) bus ();

    dac_segmented_encoder_dwa #(
        .INPUT_WIDTH(IW),
        .THERM_BITS (TB),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] therm;
        logic [5:0]  bin;
        logic        vld;
        logic        en;
        logic [3:0]  ptr;
        int          n;
        bit          chk_pop;
    } exp_t;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        vld;
        logic [9:0]  data;
        logic [14:0] therm;
        logic [5:0]  bin;
        logic [3:0]  ptr;
    } vec_t;

    exp_t        q[$];
    vec_t        vt[14];
    logic [14:0] m_lfsr;
    int          m_p;
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic logic [14:0] lfsr_step(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.therm = '0; e.bin = '0; e.vld = 1'b0; e.en = 1'b0; e.ptr = '0;
        e.n = 0; e.chk_pop = 1'b0;
        return e;
    endfunction

    task automatic check_out(input string name);
        exp_t e;
        if (q.size() >= 2) begin
            e = q.pop_front();
            n_cmp++;
            if (bus.therm_o !== e.therm || bus.binary_o !== e.bin || bus.valid_o !== e.vld ||
                bus.en_o !== e.en || bus.pointer_o !== e.ptr) begin
                n_fail++;
                $display("FAIL %s: got therm=%h bin=%h vld=%b en=%b ptr=%0d, want therm=%h bin=%h vld=%b en=%b ptr=%0d",
                         name, bus.therm_o, bus.binary_o, bus.valid_o, bus.en_o, bus.pointer_o,
                         e.therm, e.bin, e.vld, e.en, e.ptr);
            end
            if (e.chk_pop && e.vld && e.en) begin
                n_cmp++;
                if ($countones(bus.therm_o) != e.n) begin
                    n_fail++;
                    $display("FAIL %s popcount: got %0d want %0d", name, $countones(bus.therm_o), e.n);
                end
            end
        end
    endtask

    // Drive one sample, advance the reference model, push the expectation (the given one
    // for table rows, the model's otherwise), clock once and compare the oldest entry.
    task automatic apply(input logic en, input logic [1:0] mode, input logic vld,
                         input logic [9:0] data, input bit use_given, input exp_t given,
                         input string name);
        exp_t        e;
        int          n, off;
        logic [14:0] t, r;
        bus.en_i    = en;
        bus.mode_i  = mode;
        bus.valid_i = vld;
        bus.data_i  = data;
        if (en) m_lfsr = lfsr_step(m_lfsr);
        n = int'(data[9:6]);
        if (mode == 2'd1)      off = (m_lfsr[3:0] == 4'd15) ? 0 : int'(m_lfsr[3:0]);
        else if (mode == 2'd2) off = m_p;
        else                   off = 0;
        t = '0;
        r = '0;
        for (int i = 0; i < UNITS; i++) if (i < n) t[i] = 1'b1;
        for (int i = 0; i < UNITS; i++) if (t[i]) r[(i + off) % UNITS] = 1'b1;
        if (mode != 2'd2)   m_p = 0;
        else if (vld && en) m_p = (m_p + n) % UNITS;
        e.therm   = (vld && en) ? r : '0;
        e.bin     = (vld && en) ? data[5:0] : '0;
        e.vld     = vld;
        e.en      = en;
        e.ptr     = 4'(m_p);
        e.n       = n;
        e.chk_pop = 1'b1;
        q.push_back(use_given ? given : e);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    task automatic run(input logic en, input logic [1:0] mode, input logic vld,
                       input logic [9:0] data, input string name);
        apply(en, mode, vld, data, 1'b0, zero_exp(), name);
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (bus.therm_o !== '0 || bus.binary_o !== '0 || bus.valid_o !== 1'b0 ||
            bus.en_o !== 1'b0 || bus.pointer_o !== '0) begin
            n_fail++;
            $display("FAIL %s: got therm=%h bin=%h vld=%b en=%b ptr=%0d, want all zero",
                     name, bus.therm_o, bus.binary_o, bus.valid_o, bus.en_o, bus.pointer_o);
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        q.push_back(zero_exp());
        m_lfsr = SEED;
        m_p    = 0;
    endtask

    initial begin
        exp_t g;
        vt[0]  = '{1'b1, 2'd0, 1'b1, 10'h3FF, 15'h7FFF, 6'h3F, 4'd0};
        vt[1]  = '{1'b1, 2'd0, 1'b1, 10'h040, 15'h0001, 6'h00, 4'd0};
        vt[2]  = '{1'b1, 2'd0, 1'b0, 10'h3FF, 15'h0000, 6'h00, 4'd0};
        vt[3]  = '{1'b1, 2'd3, 1'b1, 10'h0C5, 15'h0007, 6'h05, 4'd0};
        vt[4]  = '{1'b1, 2'd2, 1'b1, 10'h0C0, 15'h0007, 6'h00, 4'd3};
        vt[5]  = '{1'b1, 2'd2, 1'b1, 10'h140, 15'h00F8, 6'h00, 4'd8};
        vt[6]  = '{1'b1, 2'd2, 1'b1, 10'h280, 15'h7F07, 6'h00, 4'd3};
        vt[7]  = '{1'b1, 2'd2, 1'b1, 10'h3EA, 15'h7FFF, 6'h2A, 4'd3};
        vt[8]  = '{1'b1, 2'd2, 1'b1, 10'h011, 15'h0000, 6'h11, 4'd3};
        vt[9]  = '{1'b1, 2'd0, 1'b1, 10'h040, 15'h0001, 6'h00, 4'd0};
        vt[10] = '{1'b1, 2'd2, 1'b1, 10'h100, 15'h000F, 6'h00, 4'd4};
        vt[11] = '{1'b1, 2'd2, 1'b0, 10'h100, 15'h0000, 6'h00, 4'd4};
        vt[12] = '{1'b1, 2'd2, 1'b1, 10'h100, 15'h00F0, 6'h00, 4'd8};
        vt[13] = '{1'b0, 2'd2, 1'b1, 10'h100, 15'h0000, 6'h00, 4'd8};

        bus.en_i = 1'b0; bus.mode_i = 2'd0; bus.valid_i = 1'b0; bus.data_i = '0;
        m_lfsr = SEED;
        m_p    = 0;
        #2;
        check_zero("reset_state");
        release_reset();

        // Directed table: static, mode 3, DWA wrap, n=UNITS, n=0, DWA gap, disabled.
        foreach (vt[i]) begin
            g.therm = vt[i].therm; g.bin = vt[i].bin; g.vld = vt[i].vld; g.en = vt[i].en;
            g.ptr = vt[i].ptr; g.n = int'(vt[i].data[9:6]); g.chk_pop = 1'b1;
            apply(vt[i].en, vt[i].mode, vt[i].vld, vt[i].data, 1'b1, g, $sformatf("vec%0d", i));
        end

        // DWA stream with enable low for 3 cycles while data stays valid.
        for (int i = 0; i < 12; i++) begin
            run((i >= 4 && i < 7) ? 1'b0 : 1'b1, 2'd2, 1'b1, 10'($urandom_range(0, 1023)),
                $sformatf("dwa_en_gap%0d", i));
        end
        // Same in random mode: a frozen LFSR keeps the rotation sequence aligned.
        for (int i = 0; i < 12; i++) begin
            run((i >= 5 && i < 8) ? 1'b0 : 1'b1, 2'd1, 1'b1, 10'($urandom_range(0, 1023)),
                $sformatf("rnd_en_gap%0d", i));
        end

        // Reset in the middle of a random-mode stream.
        for (int i = 0; i < 10; i++) run(1'b1, 2'd1, 1'b1, 10'($urandom_range(0, 1023)), "pre_rst");
        rst_n = 1'b0;
        #2;
        check_zero("async_reset");
        release_reset();

        // 1000 random codes; every 20th forced to full scale.
        for (int i = 0; i < 1000; i++) begin
            logic [9:0] d;
            d = 10'($urandom_range(0, 1023));
            if (i % 20 == 0) d[9:6] = 4'hF;
            run(1'b1, 2'd1, ($urandom_range(0, 7) != 0), d, $sformatf("rnd%0d", i));
        end

        // DWA random run to exercise pointer wrap widely.
        for (int i = 0; i < 100; i++) begin
            run(1'b1, 2'd2, ($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)),
                $sformatf("dwa_rnd%0d", i));
        end

        repeat (2) run(1'b0, 2'd0, 1'b0, 10'h000, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
